// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding and the PC arithmetic constants.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [31:0] PC_STEP        = 32'd4;
   localparam logic [31:0] PC_READ_OFFSET = 32'd8;
   localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Fetch address register: synchronous reset, word-aligned load, +4 increment.
// Increment wraps naturally modulo 2^32 (FFFF_FFFC -> 0000_0000).
module fetch_unit_pc_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   input  logic        i_inc,
   output logic [31:0] o_pc
);

   logic [31:0] r_pc;

   // Load wins over increment so a redirect is never lost to a same-cycle capture.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc <= RESET_PC & PC_ALIGN_MASK;
      end else if (i_load) begin
         r_pc <= i_load_val & PC_ALIGN_MASK;
      end else if (i_inc) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: REQ/WAIT/HOLD FSM feeding decode
// with registered instr/pc/pc_plus8 and branch redirect with response squash.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus8,
   output logic [1:0]  o_dbg_state
);

   state_t      r_state;
   logic        r_squash;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_pc_plus8;

   logic        w_capture;
   logic [31:0] w_fetch_pc;

   // Memory handshake: imem_req=1 for one cycle launches a fetch of imem_addr;
   // exactly one imem_valid pulse answers it 1..N cycles later. A request is
   // suppressed in a redirect cycle because that fetch would be abandoned.
   assign imem_req  = (r_state == ST_REQ) && !reset && !branch_taken;
   assign imem_addr = w_fetch_pc;

   assign w_capture = (r_state == ST_WAIT) && imem_valid && !r_squash && !branch_taken;

   fetch_unit_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_load     (branch_taken),
      .i_load_val (branch_target),
      .i_inc      (w_capture),
      .o_pc       (w_fetch_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_REQ;
         r_squash      <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instr       <= 32'h0;
         r_pc          <= 32'h0;
         r_pc_plus8    <= PC_READ_OFFSET;
      end else begin
         if (branch_taken) begin
            r_instr_valid <= 1'b0;
         end else if (w_capture) begin
            r_instr_valid <= 1'b1;
            r_instr       <= imem_rdata;
            r_pc          <= w_fetch_pc;
            r_pc_plus8    <= w_fetch_pc + PC_READ_OFFSET;
         end else if (r_instr_valid && !stall) begin
            r_instr_valid <= 1'b0;
         end

         case (r_state)
            ST_REQ: begin
               if (!branch_taken) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A redirect before the response arrives keeps us here until the stale word drains.
               if (imem_valid) begin
                  r_squash <= 1'b0;
                  r_state  <= (w_capture && stall) ? ST_HOLD : ST_REQ;
               end else if (branch_taken) begin
                  r_squash <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (branch_taken || !stall) begin
                  r_state <= ST_REQ;
               end
            end
            default: r_state <= ST_REQ;
         endcase
      end
   end

   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign pc_plus8    = r_pc_plus8;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of fetch requests, responses, redirects and decode.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, imem_req, imem_valid, branch_taken, stall, instr_valid;
   logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc, pc_plus8;
   logic [1:0]  dbg_state;

   logic        reset2, imem_req2, imem_valid2, branch_taken2, stall2, instr_valid2;
   logic [31:0] imem_addr2, imem_rdata2, branch_target2, instr2, pc2, pc_plus8_2;
   logic [1:0]  dbg_state2;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_rdata    (imem_rdata),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus8      (pc_plus8),
      .o_dbg_state   (dbg_state)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk           (clk),
      .reset         (reset2),
      .imem_req      (imem_req2),
      .imem_addr     (imem_addr2),
      .imem_valid    (imem_valid2),
      .imem_rdata    (imem_rdata2),
      .branch_taken  (branch_taken2),
      .branch_target (branch_target2),
      .stall         (stall2),
      .instr         (instr2),
      .instr_valid   (instr_valid2),
      .pc            (pc2),
      .pc_plus8      (pc_plus8_2),
      .o_dbg_state   (dbg_state2)
   );

   int checks = 0;
   int failures = 0;
   int req_count = 0;

   // Reference model: fetch intent, one outstanding memory transaction, the live decode word.
   logic        req_due, outst, squashed, holding, live_v;
   logic [31:0] exp_fetch, outst_addr, live_instr, live_pc;
   int          outst_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hE3A0_1005;
      if (a == 32'h4) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic post();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic stl, input int lat, input logic spur_en);
      logic rsp, spur, exp_req;
      logic [31:0] tgt_al;
      @(negedge clk);
      rsp  = outst && (outst_cnt == 1);
      spur = spur_en && !outst && ($urandom_range(0, 5) == 0);
      reset = rst;
      branch_taken = br;
      branch_target = tgt;
      stall = stl;
      imem_valid = rsp || spur;
      imem_rdata = rsp ? mem_word(outst_addr) : $urandom();
      #1;
      exp_req = req_due && !rst && !br;
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, exp_fetch);
      check("instr_valid", 32'(instr_valid), 32'(live_v));
      if (live_v) begin
         check("instr", instr, live_instr);
         check("pc", pc, live_pc);
         check("pc_plus8", pc_plus8, live_pc + 32'd8);
      end
      if (imem_req) req_count++;

      tgt_al = {tgt[31:2], 2'b00};
      if (rst) begin
         req_due = 1'b1; outst = 1'b0; squashed = 1'b0; holding = 1'b0; live_v = 1'b0;
         exp_fetch = 32'h0; live_instr = 32'h0; live_pc = 32'h0;
      end else begin
         if (br) live_v = 1'b0;
         else if (outst && rsp && !squashed) begin
            live_v = 1'b1; live_instr = mem_word(outst_addr); live_pc = outst_addr;
         end else if (live_v && !stl) live_v = 1'b0;

         if (exp_req) begin
            outst = 1'b1; outst_addr = exp_fetch; outst_cnt = lat; req_due = 1'b0;
         end else if (outst && rsp) begin
            outst = 1'b0;
            if (br) begin
               exp_fetch = tgt_al; squashed = 1'b0; req_due = 1'b1;
            end else if (squashed) begin
               squashed = 1'b0; req_due = 1'b1;
            end else begin
               exp_fetch = outst_addr + 32'd4;
               if (stl) holding = 1'b1;
               else req_due = 1'b1;
            end
         end else if (outst) begin
            outst_cnt--;
            if (br) begin squashed = 1'b1; exp_fetch = tgt_al; end
         end else if (holding) begin
            if (br) begin holding = 1'b0; req_due = 1'b1; exp_fetch = tgt_al; end
            else if (!stl) begin holding = 1'b0; req_due = 1'b1; end
         end else if (br) begin
            exp_fetch = tgt_al;
         end
      end
   endtask

   initial begin
      reset = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0;
      imem_valid = 1'b0; imem_rdata = 32'h0;
      reset2 = 1'b1; branch_taken2 = 1'b0; branch_target2 = 32'h0; stall2 = 1'b0;
      imem_valid2 = 1'b0; imem_rdata2 = 32'h0;
      req_due = 1'b0; outst = 1'b0; squashed = 1'b0; holding = 1'b0; live_v = 1'b0;
      exp_fetch = 32'h0; outst_addr = 32'h0; live_instr = 32'h0; live_pc = 32'h0;
      outst_cnt = 0;

      // Reset values
      step(1'b1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      post();
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus8", pc_plus8, 32'h8);
      check("rst_state", 32'(dbg_state), 32'(ST_REQ));

      // First fetch at 0, captured while decode stalls
      step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      post();
      check("first_instr", instr, 32'hE3A0_1005);
      check("first_pc", pc, 32'h0);
      check("first_pc_plus8", pc_plus8, 32'h8);
      check("first_valid", 32'(instr_valid), 32'h1);
      check("hold_no_req", 32'(imem_req), 32'h0);

      // Stall held, then released: next request at 4
      step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 2, 1'b0);
      post();
      check("resume_req", 32'(imem_req), 32'h1);
      check("resume_addr", imem_addr, 32'h4);

      // Redirect while waiting: stale DEADBEEF dropped, refetch at 0x100
      step(1'b0, 1'b0, 32'h0, 1'b0, 2, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      post();
      check("squash_valid", 32'(instr_valid), 32'h0);
      check("squash_req", 32'(imem_req), 32'h1);
      check("squash_addr", imem_addr, 32'h0000_0100);

      // Redirect coincident with the response
      step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1, 1'b0);
      post();
      check("coinc_valid", 32'(instr_valid), 32'h0);
      check("coinc_addr", imem_addr, 32'h0000_0200);

      // Reset beats a simultaneous redirect
      step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1, 1'b0);
      post();
      check("rstbr_valid", 32'(instr_valid), 32'h0);
      check("rstbr_fetch", imem_addr, 32'h0);
      check("rstbr_req", 32'(imem_req), 32'h0);

      // Throughput with 1-cycle memory: one request per two cycles
      req_count = 0;
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
      check("throughput", 32'(req_count), 32'd8);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic r_rst, r_br, r_stl;
         logic [31:0] r_tgt;
         r_rst = ($urandom_range(0, 79) == 0);
         r_br  = ($urandom_range(0, 7) == 0);
         r_stl = ($urandom_range(0, 2) == 0);
         r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom();
         step(r_rst, r_br, r_tgt, r_stl, $urandom_range(1, 3), 1'b1);
      end

      // Wrap of the fetch address from FFFF_FFFC
      @(negedge clk);
      reset2 = 1'b1;
      @(negedge clk);
      reset2 = 1'b0;
      #1;
      check("wrap_state", 32'(dbg_state2), 32'(ST_REQ));
      check("wrap_req1", 32'(imem_req2), 32'h1);
      check("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
      @(negedge clk);
      imem_valid2 = 1'b1;
      imem_rdata2 = 32'h1111_2222;
      @(negedge clk);
      imem_valid2 = 1'b0;
      #1;
      check("wrap_valid", 32'(instr_valid2), 32'h1);
      check("wrap_instr", instr2, 32'h1111_2222);
      check("wrap_pc", pc2, 32'hFFFF_FFFC);
      check("wrap_pc_plus8", pc_plus8_2, 32'h0000_0004);
      check("wrap_req2", 32'(imem_req2), 32'h1);
      check("wrap_addr2", imem_addr2, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
